instr_encoder: RTL and testbench

Packs symbolic MIPS instruction commands (mnemonic, register fields, immediate, jump target) into 32-bit machine words and streams them, tagged with sequential instruction-memory addresses, to the instruction-memory loader and the testbench. It performs the inverse of the main control/decode path: decode turns opcode and funct into control signals, and this block turns a mnemonic into opcode and funct. A small FIFO absorbs loader backpressure.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/instr_encoder.sv | 88 ++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS instruction encoder.
//   - mnemonic_e : 4-bit symbolic command codes (ADD .. JR); 10-15 are illegal
//   - OP_* / FN_*: primary opcode and R-type funct constants
//   - op_is_legal: true for the ten defined mnemonics
//   - encode     : packs a mnemonic plus fields into a 32-bit machine word;
//                  fields unused by the format are forced to zero
package mips_pkg;

  typedef enum logic [3:0] {
    MN_ADD = 4'd0,
    MN_SUB = 4'd1,
    MN_ORI = 4'd2,
    MN_LUI = 4'd3,
    MN_LW  = 4'd4,
    MN_SW  = 4'd5,
    MN_BEQ = 4'd6,
    MN_J   = 4'd7,
    MN_JAL = 4'd8,
    MN_JR  = 4'd9
  } mnemonic_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] MN_LAST = 4'd9;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= MN_LAST);
  endfunction

  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (op)
      MN_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_ADD};
      MN_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'b00000, FN_SUB};
      MN_ORI:  word = {OP_ORI, rs, rt, imm};
      MN_LUI:  word = {OP_LUI, 5'b00000, rt, imm};
      MN_LW:   word = {OP_LW, rs, rt, imm};
      MN_SW:   word = {OP_SW, rs, rt, imm};
      MN_BEQ:  word = {OP_BEQ, rs, rt, imm};
      MN_J:    word = {OP_J, target};
      MN_JAL:  word = {OP_JAL, target};
      MN_JR:   word = {OP_RTYPE, rs, 15'b0, FN_JR};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, reset (async active-high) ; push/push_data ; pop/pop_data (head)
//   full, empty, count (occupancy). Storage is cleared on reset, so the
//   head reads zero while empty after reset. Full/empty come from count.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push_s = push && !full_s;
  assign do_pop_s  = pop && !empty_s;

  // Storage array: cleared on reset, written at the tail on push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers; they wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS commands into 32-bit machine words
// tagged with sequential instruction-memory addresses.
//   clk, reset (async active-high)
//   cmd_*      : command handshake and fields (op, rs, rt, rd, imm, target)
//   out_*      : FIFO head handshake, encoded word and its address
//   bad_op     : one-cycle pulse the cycle after an illegal op is accepted
//   count      : FIFO occupancy
module instr_encoder
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [4:0]               cmd_rs,
  input  logic [4:0]               cmd_rt,
  input  logic [4:0]               cmd_rd,
  input  logic [15:0]              cmd_imm,
  input  logic [25:0]              cmd_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_addr,
  output logic                     bad_op,
  output logic [$clog2(DEPTH):0]   count
);
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [63:0] fifo_head_s;
  logic        accept_s;
  logic        legal_s;
  logic        push_s;
  logic [31:0] word_s;
  logic [31:0] addr_r;
  logic        bad_op_r;

  // Ready depends only on registered occupancy, never on valid or out_ready.
  assign cmd_ready = !fifo_full_s && !reset;
  assign accept_s  = cmd_valid && cmd_ready;
  assign legal_s   = op_is_legal(cmd_op);
  assign push_s    = accept_s && legal_s;
  assign word_s    = encode(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target);

  // Address counter: advances by one word per legal enqueue, wraps mod 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= BASE_ADDR;
    end else if (push_s) begin
      addr_r <= addr_r + 32'd4;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Illegal-op flag: high for the single cycle after an illegal acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_op_r <= 1'b0;
    end else begin
      bad_op_r <= accept_s && !legal_s;
    end
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({addr_r, word_s}),
    .pop       (out_ready),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (count)
  );

  assign out_valid = !fifo_empty_s;
  assign out_instr = fifo_head_s[31:0];
  assign out_addr  = fifo_head_s[63:32];
  assign bad_op    = bad_op_r;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector self-checking bench for instr_encoder.
// Expected words were hand-assembled from the MIPS field layouts.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs;
  logic [4:0]  cmd_rt;
  logic [4:0]  cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        bad_op;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(
    .DEPTH     (4),
    .BASE_ADDR (32'h0000_3000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_rd     (cmd_rd),
    .cmd_imm    (cmd_imm),
    .cmd_target (cmd_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .bad_op     (bad_op),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    cmd_op     = op;
    cmd_rs     = rs;
    cmd_rt     = rt;
    cmd_rd     = rd;
    cmd_imm    = imm;
    cmd_target = tgt;
  endtask

  // Present one command and hold it until accepted (bounded); returns at edge+1.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit ok;
    ok = 1'b0;
    set_cmd(op, rs, rt, rd, imm, tgt);
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", 64'(ok), 64'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Wait for a head word (bounded), check it, then consume it.
  task automatic pop(input string tag, input logic [31:0] ei, input logic [31:0] ea);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_valid"}, 64'(ok), 64'd1);
    check({tag, "_instr"}, 64'(out_instr), 64'(ei));
    check({tag, "_addr"}, 64'(out_addr), 64'(ea));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rel_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    set_cmd(4'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000000);

    // Reset state
    #1;
    check("init_ready", 64'(cmd_ready), 64'd0);
    check("init_valid", 64'(out_valid), 64'd0);
    check("init_count", 64'(count), 64'd0);
    check("init_bad", 64'(bad_op), 64'd0);
    check("init_instr", 64'(out_instr), 64'd0);
    check("init_addr", 64'(out_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("init_rel_ready", 64'(cmd_ready), 64'd1);

    // 1: ADD, latency of one edge and no bypass
    set_cmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0000000);
    cmd_valid = 1'b1;
    @(negedge clk);
    check("t1_nobypass", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_instr", 64'(out_instr), 64'h0000_0000_0022_1820);
    check("t1_addr", 64'(out_addr), 64'h0000_0000_0000_3000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("t1_drained", 64'(out_valid), 64'd0);

    // 2: ORI then LUI (rs ignored)
    apply_reset();
    send(4'd2, 5'd0, 5'd5, 5'd0, 16'h1234, 26'h0000000);
    send(4'd3, 5'd7, 5'd8, 5'd0, 16'hFFFF, 26'h0000000);
    pop("t2_ori", 32'h3405_1234, 32'h0000_3000);
    pop("t2_lui", 32'h3C08_FFFF, 32'h0000_3004);

    // 3: JAL, JR (rt/rd zeroed), then SUB, LW, J
    apply_reset();
    send(4'd8, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000C03);
    send(4'd9, 5'd31, 5'd4, 5'd9, 16'hABCD, 26'h3FFFFFF);
    pop("t3_jal", 32'h0C00_0C03, 32'h0000_3000);
    pop("t3_jr", 32'h03E0_0008, 32'h0000_3004);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 26'h0000000);
    send(4'd4, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0000000);
    send(4'd7, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF);
    pop("t3_sub", 32'h0085_3022, 32'h0000_3008);
    pop("t3_lw", 32'h8FA8_0004, 32'h0000_300C);
    pop("t3_j", 32'h0BFF_FFFF, 32'h0000_3010);

    // 4: fill to full, backpressure, drain in order, 5th gets 0x3010
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      send(4'd0, 5'd1, 5'd2, 5'(k), 16'h0000, 26'h0000000);
    end
    @(negedge clk);
    check("t4_full_ready", 64'(cmd_ready), 64'd0);
    check("t4_full_count", 64'(count), 64'd4);
    check("t4_head", 64'(out_instr), 64'h0000_0000_0022_0820);
    set_cmd(4'd0, 5'd1, 5'd2, 5'd5, 16'h0000, 26'h0000000);
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_hold_count", 64'(count), 64'd4);
    check("t4_hold_instr", 64'(out_instr), 64'h0000_0000_0022_0820);
    check("t4_hold_addr", 64'(out_addr), 64'h0000_0000_0000_3000);
    pop("t4_w1", 32'h0022_0820, 32'h0000_3000);
    check("t4_after_pop_count", 64'(count), 64'd3);
    @(negedge clk);
    check("t4_ready_again", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("t4_count5", 64'(count), 64'd4);
    for (int k = 2; k <= 5; k++) begin
      pop("t4_w", 32'h0022_0020 | (32'(k) << 11), 32'h0000_3000 + 32'(4 * (k - 1)));
    end

    // Simultaneous enqueue and dequeue keeps count
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 26'h0000000);
    set_cmd(4'd0, 5'd1, 5'd2, 5'd7, 16'h0000, 26'h0000000);
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    out_ready = 1'b0;
    check("sim_count", 64'(count), 64'd1);
    pop("sim_w", 32'h0022_3820, 32'h0000_3018);

    // 5: illegal op between SW and BEQ
    apply_reset();
    send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0000000);
    check("t5_bad_lo", 64'(bad_op), 64'd0);
    send(4'hC, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0000000);
    check("t5_bad_hi", 64'(bad_op), 64'd1);
    check("t5_count", 64'(count), 64'd1);
    @(posedge clk);
    #1;
    check("t5_bad_pulse", 64'(bad_op), 64'd0);
    send(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0000000);
    pop("t5_sw", 32'hAC43_0010, 32'h0000_3000);
    pop("t5_beq", 32'h1022_FFFE, 32'h0000_3004);
    check("t5_empty", 64'(out_valid), 64'd0);

    // 6: async reset mid-cycle discards queued words
    apply_reset();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0000000);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0000000);
    check("t6_count2", 64'(count), 64'd2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_instr", 64'(out_instr), 64'd0);
    check("t6_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0000000);
    pop("t6_add", 32'h0022_1820, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
